flex_counter_sched: RTL and testbench

FLEX_COUNTER_SCHED -- requirements
Module: flex_counter_sched

---
 rtl/flex_counter_sched.sv | 100 ++++++++++
 tb/tb_flex_counter_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_counter_sched.sv
// Round-robin scheduler that time-shares one external flex counter among
// NUM_REQ requesters, running one interval job at a time through IDLE/LOAD/COUNT/DONE.
module flex_counter_sched #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0][NUM_CNT_BITS-1:0]   req_len,
    input  logic                                   pause,
    output logic [NUM_REQ-1:0]                     grant,
    output logic [NUM_REQ-1:0]                     done,
    output logic                                   busy,
    output logic                                   cnt_clear,
    output logic                                   cnt_enable,
    output logic [NUM_CNT_BITS-1:0]                cnt_rollover_val,
    input  logic                                   cnt_rollover_flag
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [NUM_REQ-1:0]      r_grant;
    logic [IDX_W-1:0]        r_owner;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [NUM_CNT_BITS-1:0] r_len_q;

    logic [1:0]              w_next_state;
    logic                    w_win_valid;
    logic [IDX_W-1:0]        w_win_idx;
    logic [IDX_W-1:0]        w_cand;
    logic [IDX_W-1:0]        w_ptr_next;
    logic [NUM_REQ-1:0]      w_win_onehot;

    // Search starts at r_rr_ptr and wraps, so the last winner ends up with lowest priority.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_win_valid && req[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_win_idx;
    assign w_ptr_next   = IDX_W'((int'(r_owner) + 1) % NUM_REQ);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_win_valid) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = (r_len_q != '0) ? S_COUNT : S_DONE;
            S_COUNT: if (cnt_rollover_flag) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_len_q  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_win_valid) begin
                r_grant <= w_win_onehot;
                r_owner <= w_win_idx;
                r_len_q <= req_len[w_win_idx];
            end
            if (r_state == S_DONE) begin
                r_grant  <= '0;
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    // Clear is driven straight from RST so the shared counter is zeroed during every reset cycle.
    assign grant            = r_grant;
    assign done             = (r_state == S_DONE) ? r_grant : '0;
    assign busy             = (r_state != S_IDLE);
    assign cnt_clear        = RST || (r_state == S_LOAD);
    assign cnt_enable       = (r_state == S_COUNT) && !pause && !cnt_rollover_flag;
    assign cnt_rollover_val = (r_state == S_IDLE) ? '0 : r_len_q;

endmodule

// File: tb/tb_flex_counter_sched.sv
// Directed bench for flex_counter_sched with a behavioural model of the shared
// flex counter closing the loop on cnt_rollover_flag.
module tb_flex_counter_sched;

    logic            CLK;
    logic            RST;
    logic [3:0]      req;
    logic [3:0][3:0] req_len;
    logic            pause;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic            busy;
    logic            cnt_clear;
    logic            cnt_enable;
    logic [3:0]      cnt_rollover_val;
    logic            cnt_rollover_flag;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_count;
    logic       m_flag;
    logic [3:0] m_next;

    flex_counter_sched #(.NUM_REQ(4), .NUM_CNT_BITS(4)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .req               (req),
        .req_len           (req_len),
        .pause             (pause),
        .grant             (grant),
        .done              (done),
        .busy              (busy),
        .cnt_clear         (cnt_clear),
        .cnt_enable        (cnt_enable),
        .cnt_rollover_val  (cnt_rollover_val),
        .cnt_rollover_flag (cnt_rollover_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared flex counter: counts 1..rollover_val, registered flag when the next count hits it.
    assign m_next            = (m_count == cnt_rollover_val) ? 4'd1 : m_count + 4'd1;
    assign cnt_rollover_flag = m_flag;

    always @(posedge CLK) begin
        if (cnt_clear) begin
            m_count <= 4'd0;
            m_flag  <= 1'b0;
        end else if (cnt_enable) begin
            m_count <= m_next;
            m_flag  <= (m_next == cnt_rollover_val);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one job whose req was driven during the current IDLE cycle t.
    // req_mode: 0 hold req, 1 drop req at done, 2 drop req right after grant.
    task automatic do_job(input string name, input logic [3:0] exp_grant, input int n,
                          input int p_start, input int p_len, input int req_mode,
                          input int post_len);
        int cyc, enables, done_cyc, pulses, exp_done;
        bit finished;
        exp_done = (n == 0) ? 2 : n + 3 + p_len;

        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_busy: got %b expected 0", name, busy);
        end

        tick();
        checks++;
        if (grant !== exp_grant) begin
            failures++;
            $display("FAIL %s_grant: got %b expected %b", name, grant, exp_grant);
        end
        checks++;
        if (cnt_clear !== 1'b1 || cnt_enable !== 1'b0) begin
            failures++;
            $display("FAIL %s_load: clear=%b enable=%b expected clear=1 enable=0",
                     name, cnt_clear, cnt_enable);
        end
        if (post_len >= 0)
            for (int i = 0; i < 4; i++)
                if (exp_grant[i]) req_len[i] = 4'(post_len);
        if (req_mode == 2) req = 4'b0000;

        cyc = 1; enables = 0; done_cyc = -1; pulses = 0; finished = 1'b0;
        while (!finished && cyc < 64) begin
            tick();
            cyc++;
            pause = (cyc >= p_start) && (cyc < p_start + p_len);
            #1;
            if (cnt_enable === 1'b1) enables++;
            checks++;
            if ($countones(grant) > 1 || (done & ~grant) != 4'b0000) begin
                failures++;
                $display("FAIL %s_onehot: grant=%b done=%b", name, grant, done);
            end
            if (done !== 4'b0000) begin
                pulses++;
                done_cyc = cyc;
                checks++;
                if (done !== exp_grant) begin
                    failures++;
                    $display("FAIL %s_done_val: got %b expected %b", name, done, exp_grant);
                end
                if (req_mode == 1) req = 4'b0000;
            end
            if (busy === 1'b0) finished = 1'b1;
        end
        pause = 1'b0;

        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles", name, busy, cyc);
        end
        checks++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s_done_cycle: got t+%0d expected t+%0d", name, done_cyc, exp_done);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL %s_done_pulses: got %0d expected 1", name, pulses);
        end
        checks++;
        if (enables != n) begin
            failures++;
            $display("FAIL %s_enables: got %0d expected %0d", name, enables, n);
        end
        checks++;
        if (m_count !== 4'(n)) begin
            failures++;
            $display("FAIL %s_counter: got %0d expected %0d", name, m_count, n);
        end
        checks++;
        if (cyc != exp_done + 1 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL %s_idle_after: cycle t+%0d grant=%b expected t+%0d grant=0000",
                     name, cyc, grant, exp_done + 1);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 ||
            cnt_enable !== 1'b0 || cnt_rollover_val !== 4'd0 || cnt_clear !== 1'b1) begin
            failures++;
            $display("FAIL %s: grant=%b done=%b busy=%b en=%b rv=%0d clr=%b expected 0000 0000 0 0 0 1",
                     name, grant, done, busy, cnt_enable, cnt_rollover_val, cnt_clear);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; req = 4'b0000; pause = 1'b0; req_len = '0;
        tick();
        tick();
        check_reset_outputs("reset_state");
        RST = 1'b0;
        #1;
        checks++;
        if (cnt_clear !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_clear: got %b expected 0", cnt_clear);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        req_len = {4'd2, 4'd2, 4'd2, 4'd2};
        req = 4'b1111;
        do_job("b2b_0", 4'b0001, 2, 0, 0, 0, -1);
        do_job("b2b_1", 4'b0010, 2, 0, 0, 0, -1);
        do_job("b2b_2", 4'b0100, 2, 0, 0, 0, -1);
        do_job("b2b_3", 4'b1000, 2, 0, 0, 0, -1);
        do_job("b2b_4", 4'b0001, 2, 0, 0, 1, -1);
    endtask

    task automatic test_single();
        req_len[0] = 4'd5;
        req = 4'b0001;
        do_job("single", 4'b0001, 5, 0, 0, 1, -1);
    endtask

    task automatic test_pause();
        req_len[2] = 4'd3;
        req = 4'b0100;
        do_job("pause", 4'b0100, 3, 3, 4, 1, -1);
    endtask

    task automatic test_zero_len();
        req_len[1] = 4'd0;
        req = 4'b0010;
        do_job("zero_len", 4'b0010, 0, 0, 0, 1, -1);
    endtask

    task automatic test_len_change();
        req_len[1] = 4'd4;
        req = 4'b0010;
        do_job("len_change", 4'b0010, 4, 0, 0, 2, 9);
    endtask

    task automatic test_reset_mid_job();
        req_len[2] = 4'd7;
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL rst_job_grant: got %b expected 0100", grant);
        end
        tick();
        tick();
        checks++;
        if (cnt_enable !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_job_counting: en=%b busy=%b expected 1 1", cnt_enable, busy);
        end
        RST = 1'b1;
        req = 4'b0000;
        #1;
        checks++;
        if (cnt_clear !== 1'b1) begin
            failures++;
            $display("FAIL rst_async_clear: got %b expected 1", cnt_clear);
        end
        tick();
        check_reset_outputs("rst_mid_first");
        tick();
        check_reset_outputs("rst_mid_second");
        RST = 1'b0;
        #1;
        checks++;
        if (cnt_clear !== 1'b0 || m_count !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_release: clr=%b count=%0d expected 0 0", cnt_clear, m_count);
        end
        req_len[0] = 4'd1;
        req_len[3] = 4'd1;
        req = 4'b1001;
        do_job("rst_rr_ptr0", 4'b0001, 1, 0, 0, 1, -1);
        req = 4'b1000;
        do_job("rst_req3", 4'b1000, 1, 0, 0, 1, -1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_pause();
        test_zero_len();
        test_len_change();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
